window_addr_gen: RTL and testbench
==================================

# window_addr_gen

Address-generation front end for the 3x3 rank-order/median filter over a 64x64 8-bit image held in a 4097-entry pixel RAM. Entry 4096 is a constant-zero pad cell.
- Scans the image in raster order and latches the current centre pixel's row/column.
- Emits the nine window read addresses, substituting the pad address for out-of-image neighbours.
- Emits the write address and write strobe for the filtered result, delayed to match the downstream filter latency.
- Sits between the pixel RAM / rank-order filter and the result buffer.

## Interface
Parameters:
- IMG_W, 64: image width; power of two.
- IMG_H, 64: image height; power of two.
- FILT_LAT, 1: clock cycles from window addresses valid to filter result valid.

Ports:
- iClk  in  1  single clock; all state on rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iEn  in  1  scan enable; low freezes all state.
- oRow  out  6  centre row of current window (registered).
- oCol  out  6  centre column of current window (registered).
- oAddrP11..oAddrP33  out  13 each  window read addresses; Prc is row r, column c, and P22 is the centre.
- oAddrPixel  out  13  result write address; holds 4096 when the scan is done.
- oWrite  out  1  result write strobe.
- oDone  out  1  scan complete; sticky until reset.

## Operation
- N = IMG_W*IMG_H = 4096. PAD = N.
- Address width AW = log2(N)+1 = 13. Pixel address = row*IMG_W + col.
- Scan counter cnt (AW+1 bits) runs from 0 to N-1+D, then holds, where D = 1+FILT_LAT.
- Read index = cnt while cnt<N; otherwise it holds at N-1.
- Centre register: on each enabled edge, oRow/oCol ← read index split into row (upper bits) and col (lower 6 bits).
- Window decode is combinational from oRow/oCol. For dr,dc in {-1,0,+1}, the address is (row+dr)*IMG_W + (col+dc).
- If row+dr is outside 0..IMG_H-1, or col+dc is outside 0..IMG_W-1, the address is PAD instead.
- Comparisons use signed or extended arithmetic; no wrap-around into adjacent rows.
- Write side:
  - oWrite = 1 iff D ≤ cnt ≤ N-1+D.
  - oAddrPixel = cnt-D while oWrite = 1.
  - oAddrPixel = 0 before the first write.
  - oAddrPixel = PAD once cnt = N-1+D has been passed, i.e. one cycle after the last write.
- oDone is set on the cycle oAddrPixel first equals PAD and stays set; cnt stops advancing.
- iEn low: cnt, oRow, oCol, oDone hold, and oWrite is forced to 0.

## Timing
- Reset values:
  - cnt = 0, oRow = 0, oCol = 0.
  - oWrite = 0, oAddrPixel = 0, oDone = 0.
  - Window outputs follow from centre (0,0): P11/P12/P13/P21/P31 = 4096, P22 = 0, P23 = 1, P32 = 64, P33 = 65.
- Pixel n is read-indexed at cnt = n. Its window addresses are valid from the next edge, and the filter result is ready FILT_LAT cycles later.
- oWrite with oAddrPixel = n is asserted at cnt = n+D. The consumer samples the result on that edge.
- The first write is D cycles after reset release with iEn high. The last write (address 4095) is at cnt = 4095+D. oAddrPixel = 4096 and oDone = 1 appear one cycle later.
- Throughput: one pixel per enabled clock. No back-pressure beyond iEn.
- Reset asserted mid-scan returns every output to its reset value immediately (asynchronous). Scanning restarts from pixel 0 after release.

## Structure
- Shared package:
  - constants IMG_W, IMG_H, N_PIX, PAD_ADDR, ADDR_W, ROW_W, COL_W;
  - typedef addr_t (ADDR_W bits).
- One combinational sub-module, window_addr_decode: inputs row/col, outputs the nine addresses with pad substitution.
- Counter, centre register and write-delay logic sit in the top level.

## Test plan
- Reset then release with iEn=1 -> after the first edge, centre (0,0) with P11,P12,P13,P21,P31 = 4096, P22 = 0, P23 = 1, P32 = 64, P33 = 65. oWrite = 0 until cnt = D.
- Interior pixel 330 (row 5, col 10) -> P11..P33 = 265, 266, 267, 329, 330, 331, 393, 394, 395.
- Corner pixel 4095 (63,63) -> P11 = 4030, P12 = 4031, P21 = 4094, P22 = 4095, P13/P23/P31/P32/P33 = 4096.
- Row edges: pixel 63 (row 0, col 63) -> P23 = 4096 (not 64) and P32 = 127; pixel 64 (row 1, col 0) -> P21 = 4096 (not 63) and P22 = 64.
- Full scan with FILT_LAT=1 -> exactly 4096 oWrite pulses on consecutive cycles with addresses 0..4095 in order. oAddrPixel = 4096 and oDone = 1 on the following cycle, and both hold.
- Mid-scan events:
  - iEn low for 3 cycles mid-scan -> no writes and no address advance; the sequence resumes with no gap or duplicate.
  - iRst_n asserted mid-scan -> outputs reset immediately.

Source files
------------

// File: rtl/window_addr_gen_pkg.sv
// Shared constants and types for the 3x3 window address generator.
// Defaults describe a 64x64 image with one trailing constant-zero pad cell.
package window_addr_gen_pkg;

    localparam int IMG_W    = 64;
    localparam int IMG_H    = 64;
    localparam int N_PIX    = IMG_W * IMG_H;
    localparam int PAD_ADDR = N_PIX;
    localparam int ADDR_W   = $clog2(N_PIX) + 1;
    localparam int ROW_W    = $clog2(IMG_H);
    localparam int COL_W    = $clog2(IMG_W);

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/window_addr_decode.sv
// Combinational 3x3 neighbourhood decode around a centre pixel.
// Neighbours that fall outside the image map to the pad address.
module window_addr_decode #(
    parameter int IMG_W    = window_addr_gen_pkg::IMG_W,
    parameter int IMG_H    = window_addr_gen_pkg::IMG_H,
    localparam int COL_W   = $clog2(IMG_W),
    localparam int ROW_W   = $clog2(IMG_H),
    localparam int ADDR_W  = $clog2(IMG_W * IMG_H) + 1
) (
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr [9]
);

    always_comb begin
        int rr;
        int cc;
        rr   = 0;
        cc   = 0;
        addr = '{default: '0};
        // Signed int arithmetic so col-1 at col 0 goes negative instead of wrapping.
        for (int k = 0; k < 9; k++) begin
            rr = int'(row) + (k / 3) - 1;
            cc = int'(col) + (k % 3) - 1;
            if (rr < 0 || rr >= IMG_H || cc < 0 || cc >= IMG_W) begin
                addr[k] = ADDR_W'(IMG_W * IMG_H);
            end else begin
                addr[k] = ADDR_W'(rr * IMG_W + cc);
            end
        end
    end

endmodule

// File: rtl/window_addr_gen.sv
// Raster-scan front end: centre register, window read addresses and a
// write address/strobe delayed by the downstream filter latency.
module window_addr_gen #(
    parameter int IMG_W    = window_addr_gen_pkg::IMG_W,
    parameter int IMG_H    = window_addr_gen_pkg::IMG_H,
    parameter int FILT_LAT = 1,
    localparam int COL_W   = $clog2(IMG_W),
    localparam int ROW_W   = $clog2(IMG_H),
    localparam int ADDR_W  = $clog2(IMG_W * IMG_H) + 1
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iEn,
    output logic [ROW_W-1:0]  oRow,
    output logic [COL_W-1:0]  oCol,
    output logic [ADDR_W-1:0] oAddrP11,
    output logic [ADDR_W-1:0] oAddrP12,
    output logic [ADDR_W-1:0] oAddrP13,
    output logic [ADDR_W-1:0] oAddrP21,
    output logic [ADDR_W-1:0] oAddrP22,
    output logic [ADDR_W-1:0] oAddrP23,
    output logic [ADDR_W-1:0] oAddrP31,
    output logic [ADDR_W-1:0] oAddrP32,
    output logic [ADDR_W-1:0] oAddrP33,
    output logic [ADDR_W-1:0] oAddrPixel,
    output logic              oWrite,
    output logic              oDone
);

    localparam int N     = IMG_W * IMG_H;
    localparam int D     = 1 + FILT_LAT;
    localparam int CNT_W = ADDR_W + 1;
    localparam int IDX_W = ADDR_W - 1;

    localparam logic [CNT_W-1:0]  N_CNT    = CNT_W'(N);
    localparam logic [CNT_W-1:0]  D_CNT    = CNT_W'(D);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N - 1 + D);
    localparam logic [ADDR_W-1:0] PAD      = ADDR_W'(N);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              done_q, done_d;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_window;
    logic [ADDR_W-1:0] addr_pixel;
    logic [ADDR_W-1:0] win [9];

    always_comb begin
        cnt_d  = cnt_q;
        row_d  = row_q;
        col_d  = col_q;
        done_d = done_q;
        // Past the last pixel the read side parks on pixel N-1 while writes drain.
        rd_idx = (cnt_q < N_CNT) ? cnt_q[IDX_W-1:0] : '1;
        if (iEn) begin
            row_d = rd_idx[IDX_W-1:COL_W];
            col_d = rd_idx[COL_W-1:0];
            if (!done_q) begin
                if (cnt_q == LAST_CNT) begin
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_window = !done_q && (cnt_q >= D_CNT) && (cnt_q <= LAST_CNT);
        if (done_q) begin
            addr_pixel = PAD;
        end else if (cnt_q >= D_CNT) begin
            addr_pixel = ADDR_W'(cnt_q - D_CNT);
        end else begin
            addr_pixel = '0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            row_q  <= row_d;
            col_q  <= col_d;
            done_q <= done_d;
        end
    end

    window_addr_decode #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_decode (
        .row  (row_q),
        .col  (col_q),
        .addr (win)
    );

    assign oRow       = row_q;
    assign oCol       = col_q;
    assign oAddrP11   = win[0];
    assign oAddrP12   = win[1];
    assign oAddrP13   = win[2];
    assign oAddrP21   = win[3];
    assign oAddrP22   = win[4];
    assign oAddrP23   = win[5];
    assign oAddrP31   = win[6];
    assign oAddrP32   = win[7];
    assign oAddrP33   = win[8];
    assign oAddrPixel = addr_pixel;
    assign oWrite     = iEn && wr_window;
    assign oDone      = done_q;

endmodule

// File: tb/tb_window_addr_gen.sv
// Randomized-enable bench for window_addr_gen against a pixel-index model,
// a write-address scoreboard and fixed neighbourhood tables.
module tb_window_addr_gen;

    localparam int W    = 64;
    localparam int H    = 64;
    localparam int N    = W * H;
    localparam int D    = 2;
    localparam int LAST = N - 1 + D;

    logic        iClk;
    logic        iRst_n;
    logic        iEn;
    logic [5:0]  oRow;
    logic [5:0]  oCol;
    logic [12:0] oAddrP11, oAddrP12, oAddrP13;
    logic [12:0] oAddrP21, oAddrP22, oAddrP23;
    logic [12:0] oAddrP31, oAddrP32, oAddrP33;
    logic [12:0] oAddrPixel;
    logic        oWrite;
    logic        oDone;
    logic [12:0] win [9];

    int n_checks = 0;
    int n_errors = 0;
    int t        = 0;
    int wr_count = 0;
    logic [12:0] exp_q [$];

    int tbl_px [5] = '{0, 63, 64, 330, 4095};
    int tbl [5][9] = '{
        '{4096, 4096, 4096, 4096, 0, 1, 4096, 64, 65},
        '{4096, 4096, 4096, 62, 63, 4096, 126, 127, 4096},
        '{4096, 0, 1, 4096, 64, 65, 4096, 128, 129},
        '{265, 266, 267, 329, 330, 331, 393, 394, 395},
        '{4030, 4031, 4096, 4094, 4095, 4096, 4096, 4096, 4096}
    };

    window_addr_gen #(
        .FILT_LAT (1)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iEn        (iEn),
        .oRow       (oRow),
        .oCol       (oCol),
        .oAddrP11   (oAddrP11),
        .oAddrP12   (oAddrP12),
        .oAddrP13   (oAddrP13),
        .oAddrP21   (oAddrP21),
        .oAddrP22   (oAddrP22),
        .oAddrP23   (oAddrP23),
        .oAddrP31   (oAddrP31),
        .oAddrP32   (oAddrP32),
        .oAddrP33   (oAddrP33),
        .oAddrPixel (oAddrPixel),
        .oWrite     (oWrite),
        .oDone      (oDone)
    );

    assign win[0] = oAddrP11;
    assign win[1] = oAddrP12;
    assign win[2] = oAddrP13;
    assign win[3] = oAddrP21;
    assign win[4] = oAddrP22;
    assign win[5] = oAddrP23;
    assign win[6] = oAddrP31;
    assign win[7] = oAddrP32;
    assign win[8] = oAddrP33;

    // clock
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int model_win(int c, int k);
        int r;
        int cc;
        r  = c / W + k / 3 - 1;
        cc = c % W + k % 3 - 1;
        if (r < 0 || r >= H || cc < 0 || cc >= W) return N;
        return r * W + cc;
    endfunction

    task automatic model_reset();
        t        = 0;
        wr_count = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(13'(i));
    endtask

    task automatic check_all();
        int c;
        int exp_ap;
        logic [12:0] sb_exp;
        // t counts enabled edges since reset; centre is the pixel indexed one edge earlier
        c = (t == 0) ? 0 : ((t - 1 > N - 1) ? N - 1 : t - 1);
        exp_ap = (t > LAST) ? N : ((t >= D) ? t - D : 0);
        check("row", oRow, c / W);
        check("col", oCol, c % W);
        for (int k = 0; k < 9; k++) check($sformatf("win%0d", k), win[k], model_win(c, k));
        for (int p = 0; p < 5; p++) begin
            if (c == tbl_px[p]) begin
                for (int k = 0; k < 9; k++)
                    check($sformatf("px%0d_p%0d%0d", c, k / 3 + 1, k % 3 + 1), win[k], tbl[p][k]);
            end
        end
        check("write", oWrite, (iEn && t >= D && t <= LAST) ? 1 : 0);
        check("addr_pixel", oAddrPixel, exp_ap);
        check("done", oDone, (t > LAST) ? 1 : 0);
        if (oWrite === 1'b1) begin
            wr_count++;
            sb_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h1fff;
            check("sb_addr", oAddrPixel, sb_exp);
        end
    endtask

    // driver: one clock with the given enable, checked before the edge
    task automatic cycle(input logic en);
        @(negedge iClk);
        iEn = en;
        #1;
        check_all();
        @(posedge iClk);
        if (en && iRst_n && t <= LAST) t++;
    endtask

    function automatic logic rand_en();
        return ($urandom_range(0, 7) != 0);
    endfunction

    initial begin
        int guard;
        iRst_n = 1'b0;
        iEn    = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge iClk);
        iRst_n = 1'b1;

        // partial scan with random enables and one forced 3-cycle stall
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                cycle(1'b0);
                cycle(1'b0);
                cycle(1'b0);
            end
            cycle(rand_en());
        end

        // asynchronous reset between edges
        @(negedge iClk);
        #2;
        iEn    = 1'b1;
        iRst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge iClk);
        @(negedge iClk);
        iEn    = 1'b0;
        iRst_n = 1'b1;
        #1;
        check_all();

        // complete scan from pixel 0
        guard = 0;
        while (t <= LAST && guard < 20000) begin
            cycle(rand_en());
            guard++;
        end
        check("scan_finished", (t > LAST) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) cycle(1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0);
        check("wr_count", wr_count, N);
        check("sb_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
